// File: rtl/axis_eth_pad_if.sv
// Byte-wide AXI-Stream bundle shared by the pad stage's upstream and downstream ports.
// A beat transfers on a rising clk edge where tvalid & tready are both high; once tvalid is raised
// the source holds tvalid, tdata and tlast stable until that transfer, and tready may change freely.
interface axis_eth_pad_if;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic [7:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_eth_pad.sv
// Pads short Ethernet frames up to MIN_BYTES with PAD_BYTE and forces GAP_CYCLES idle cycles
// after every frame. Data passes combinationally; there is no internal byte storage.
module axis_eth_pad #(
    parameter int         MIN_BYTES  = 60,
    parameter logic [7:0] PAD_BYTE   = 8'h00,
    parameter int         GAP_CYCLES = 12
) (
    input  logic                  clk,
    input  logic                  areset,
    axis_eth_pad_if.slave         axis_i,
    axis_eth_pad_if.master        axis_o,
    output logic [1:0]            state_dbg
);
    localparam int CW = $clog2(MIN_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MIN_BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(MIN_BYTES - 1);
    localparam logic [CW:0]   MIN_EXT  = (CW + 1)'(MIN_BYTES);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_PAD  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [GW-1:0] gap_q, gap_n;
    logic [CW:0]   cnt_inc;
    logic          reach_min;
    logic          o_tvalid, o_tlast, i_tready;
    logic [7:0]    o_tdata;

    // One extra bit so the saturated count plus one never wraps.
    assign cnt_inc   = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
    assign reach_min = (cnt_inc >= MIN_EXT);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_PASS;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            gap_q   <= gap_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        gap_n    = gap_q;
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_tdata  = axis_i.tdata;
        i_tready = 1'b0;

        case (state_q)
            ST_PASS: begin
                o_tvalid = axis_i.tvalid;
                o_tlast  = axis_i.tlast & reach_min;
                i_tready = axis_o.tready;
                if (axis_i.tvalid && axis_o.tready) begin
                    if (axis_i.tlast && reach_min) begin
                        cnt_n = '0;
                        if (GAP_CYCLES > 0) begin
                            state_n = ST_GAP;
                            gap_n   = GAP_LOAD;
                        end
                    end else if (axis_i.tlast) begin
                        // Short frame: swallow upstream tlast, finish with pad bytes.
                        cnt_n   = cnt_inc[CW-1:0];
                        state_n = ST_PAD;
                    end else begin
                        cnt_n = reach_min ? CNT_MAX : cnt_inc[CW-1:0];
                    end
                end
            end

            ST_PAD: begin
                o_tvalid = 1'b1;
                o_tdata  = PAD_BYTE;
                o_tlast  = (cnt_q == CNT_LAST);
                if (axis_o.tready) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_n = '0;
                        if (GAP_CYCLES > 0) begin
                            state_n = ST_GAP;
                            gap_n   = GAP_LOAD;
                        end else begin
                            state_n = ST_PASS;
                        end
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
            end

            ST_GAP: begin
                // Counts wall-clock cycles; downstream ready has no influence here.
                if (gap_q == '0) begin
                    state_n = ST_PASS;
                end else begin
                    gap_n = gap_q - {{(GW-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_n = ST_PASS;
                cnt_n   = '0;
                gap_n   = '0;
            end
        endcase

        if (areset) begin
            o_tvalid = 1'b0;
            i_tready = 1'b0;
        end
    end

    assign axis_o.tvalid = o_tvalid;
    assign axis_o.tlast  = o_tlast;
    assign axis_o.tdata  = o_tdata;
    assign axis_i.tready = i_tready;
    assign state_dbg     = state_q;
endmodule
